inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage. Holds the PC and issues word reads to instruction memory over a valid/ready
//  request + valid-only response bus. Buffers returned words with their PC in a small FIFO and presents
//  them to decode (immediate generation / control decode) through a valid/ready handshake.
//  Handles PC redirects (branch/jump/trap) by flushing the buffer and discarding stale in-flight responses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH  2              instruction buffer entries; also the max in-flight + buffered words (>=1)
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst             in   1   synchronous, active-high reset
//  redirect_valid  in   1   load new PC this cycle (from execute/trap logic)
//  redirect_pc     in   32  redirect target (word_t)
//  mem_req_valid   out  1   read request valid
//  mem_req_ready   in   1   memory accepts request
//  mem_req_addr    out  32  word-aligned fetch address
//  mem_rsp_valid   in   1   read data valid (in order, no backpressure)
//  mem_rsp_data    in   32  instruction word
//  out_valid       out  1   instruction available to decode
//  out_ready       in   1   decode consumes instruction
//  out_inst        out  32  instruction word (word_t)
//  out_pc          out  32  PC of out_inst
//  out_exc         out  1   instruction-address-misaligned flag (only with IFETCH_MISALIGN_EXC_EN)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, in_flight=0, drop_cnt=0, stale=0; outputs mem_req_valid=0,
//    out_valid=0, out_inst=0, out_pc=0, out_exc=0. First request in cycle after rst falls.
//  - Credit: mem_req_valid=1 iff in_flight + fifo_count < FIFO_DEPTH (response always has space).
//    Once asserted, mem_req_valid and mem_req_addr hold stable until mem_req_ready (no withdrawal).
//  - Accept (valid&ready): in_flight+1; pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0); per-request PC queued.
//  - Response: in_flight-1; if drop_cnt>0, drop_cnt-1 and data discarded; else {data,pc} pushed.
//    Accept and response in same cycle: in_flight unchanged.
//  - Output: FIFO head registered; response -> out_valid earliest next cycle (1-cycle latency).
//    Pop on out_valid&out_ready. Push+pop same cycle on full FIFO legal (count unchanged).
//  - Redirect at cycle t (priority over normal pc update): pc <= redirect_pc; FIFO flushed;
//    out_valid=0 at t+1; a pop at t still completes; drop_cnt <= in_flight after t's accept/response;
//    if a request is pending unaccepted at t, stale<=1: on its accept it is counted into drop_cnt and
//    pc is NOT advanced (next req uses redirect_pc). Redirect back-to-back each cycle: last wins.
//  - Bus low bits: mem_req_addr[1:0] forced 2'b00.
//  - rst mid-operation: all state cleared; responses after reset for pre-reset requests are undefined
//    (memory is reset with the core).
// CONFIGURATION
//  IFETCH_MISALIGN_EXC_EN defined: redirect_pc[1:0]!=0 -> no fetch issued; one entry {inst=0,
//    pc=redirect_pc, exc=1} presented; fetch halts until next redirect. out_exc=1 only on that entry.
//  Undefined: redirect_pc[1:0] ignored (truncated to word), out_exc tied 0, port still present.
// TESTING
//  1 Reset, mem always ready, 1-cycle rsp -> reqs at 0,4,8..; out_pc 0,4,8 with matching insts.
//  2 out_ready=0 for 10 cycles, DEPTH=2 -> at most 2 accepted, req_valid low, no word lost.
//  3 Redirect to 0x100 with 2 in flight -> both rsps dropped, next out_pc=0x100, no stale entry.
//  4 mem_req_ready=0 at redirect to 0x200 -> held req (old addr) accepted then dropped; next req 0x200.
//  5 Redirect to 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0000_0000.
//  6 EN set, redirect to 0x102 -> out_valid, out_exc=1, out_pc=0x102, no req until next redirect.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response bus and decode-side handshake.
// master = fetch stage, slave = the environment (memory + execute + decode).
interface inst_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_exc;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc, out_exc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc, out_exc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, credit-limited word requests, in-order response buffer, redirect flush.
// Optional IFETCH_MISALIGN_EXC_EN turns a misaligned redirect into a single exception entry.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          run;
    logic [31:0]   pc;
    logic [31:0]   stale_pc;
    logic          stale;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] in_flight_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fcount;
    logic [PW-1:0] qwr, qrd, fwr, frd;
    logic [31:0]   qpc   [FIFO_DEPTH];
    logic [31:0]   finst [FIFO_DEPTH];
    logic [31:0]   fpc   [FIFO_DEPTH];

    logic          halted;
    logic          exc_ent;
    logic [31:0]   exc_pc;
    logic          credit, req_valid, accept, rsp, drop_now, push, pop;
    logic [31:0]   req_addr, target;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every slot is either in flight or buffered, so a response never finds the buffer full.
    assign credit    = ({1'b0, in_flight} + {1'b0, fcount}) < (CW+1)'(FIFO_DEPTH);
    assign req_valid = run & credit & (~halted | stale);
    assign req_addr  = {pc[31:2], 2'b00};
    assign target    = {bus.redirect_pc[31:2], 2'b00};
    assign accept    = req_valid & bus.mem_req_ready;
    assign rsp       = bus.mem_rsp_valid;
    assign drop_now  = rsp & (drop_cnt != '0);
    assign push      = rsp & (drop_cnt == '0) & ~bus.redirect_valid;
    assign pop       = bus.out_ready & (fcount != '0);

    assign in_flight_next = in_flight + CW'(accept) - CW'(rsp);

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = req_addr;
    assign bus.out_valid     = exc_ent | (fcount != '0);
    assign bus.out_inst      = (fcount != '0) ? finst[frd] : 32'h0;
    assign bus.out_pc        = exc_ent ? exc_pc : ((fcount != '0) ? fpc[frd] : 32'h0);
    assign bus.out_exc       = exc_ent;

    // A request still waiting for ready at a redirect must keep its address, so the new
    // target is parked in stale_pc and the held request is dropped once it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            run       <= 1'b0;
            pc        <= RESET_PC;
            stale     <= 1'b0;
            stale_pc  <= '0;
            in_flight <= '0;
            drop_cnt  <= '0;
            fcount    <= '0;
            qwr       <= '0;
            qrd       <= '0;
            fwr       <= '0;
            frd       <= '0;
        end else begin
            run       <= 1'b1;
            in_flight <= in_flight_next;
            if (accept) qwr <= nxt(qwr);
            if (rsp)    qrd <= nxt(qrd);
            if (bus.redirect_valid) begin
                drop_cnt <= in_flight_next;
                fcount   <= '0;
                fwr      <= '0;
                frd      <= '0;
                if (req_valid && !bus.mem_req_ready) begin
                    stale    <= 1'b1;
                    stale_pc <= target;
                end else begin
                    stale <= 1'b0;
                    pc    <= target;
                end
            end else begin
                drop_cnt <= drop_cnt + CW'(accept & stale) - CW'(drop_now);
                fcount   <= fcount + CW'(push) - CW'(pop);
                if (push) fwr <= nxt(fwr);
                if (pop)  frd <= nxt(frd);
                if (accept) begin
                    if (stale) begin
                        pc    <= stale_pc;
                        stale <= 1'b0;
                    end else begin
                        pc <= pc + 32'd4;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) qpc[qwr] <= req_addr;
        if (push) begin
            finst[fwr] <= bus.mem_rsp_data;
            fpc[fwr]   <= qpc[qrd];
        end
    end

`ifdef IFETCH_MISALIGN_EXC_EN
    logic exc_arm;
    logic misalign;

    assign misalign = bus.redirect_pc[1:0] != 2'b00;

    // The exception entry is armed first so the output is empty in the cycle after the redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted  <= 1'b0;
            exc_arm <= 1'b0;
            exc_ent <= 1'b0;
            exc_pc  <= '0;
        end else if (bus.redirect_valid) begin
            halted  <= misalign;
            exc_arm <= misalign;
            exc_ent <= 1'b0;
            exc_pc  <= bus.redirect_pc;
        end else begin
            if (exc_arm) begin
                exc_ent <= 1'b1;
                exc_arm <= 1'b0;
            end else if (exc_ent && bus.out_ready) begin
                exc_ent <= 1'b0;
            end
        end
    end
`else
    logic unused_lo;

    assign unused_lo = ^bus.redirect_pc[1:0];
    assign halted    = 1'b0;
    assign exc_ent   = 1'b0;
    assign exc_pc    = '0;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: table-driven streaming check plus hand-written backpressure,
// redirect, wrap and misaligned-target sequences against a queue-based memory model.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst;
    logic mem_hold;
    int   acc_cnt;
    int   compared = 0;
    int   mismatched = 0;
    logic [31:0] pendq[$];

    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        mem_ready;
        logic        out_ready;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_out_valid;
        logic [31:0] exp_out_pc;
    } row_t;

    row_t rows [7];

    // Memory model: in order, answers the cycle after accept unless held; data is ~address.
    always @(posedge clk) begin
        if (rst) begin
            pendq.delete();
            acc_cnt <= 0;
            bus.mem_rsp_valid <= 1'b0;
            bus.mem_rsp_data  <= 32'h0;
        end else begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                pendq.push_back(bus.mem_req_addr);
                acc_cnt <= acc_cnt + 1;
            end
            if (!mem_hold && pendq.size() > 0) begin
                bus.mem_rsp_valid <= 1'b1;
                bus.mem_rsp_data  <= ~pendq.pop_front();
            end else begin
                bus.mem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input row_t r);
        bus.mem_req_ready = r.mem_ready;
        bus.out_ready     = r.out_ready;
    endtask

    task automatic doReset();
        rst = 1'b1;
        mem_hold = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.mem_req_ready  = 1'b1;
        bus.out_ready      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic doRedirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic drainExpect(input string name, input logic [31:0] start, input int n);
        logic [31:0] exp_pc;
        int got;
        int cyc;
        exp_pc = start;
        got = 0;
        cyc = 0;
        bus.out_ready = 1'b1;
        while (got < n && cyc < 40) begin
            if (bus.out_valid) begin
                checkOutput({name, " out_pc"}, bus.out_pc, exp_pc);
                checkOutput({name, " out_inst"}, bus.out_inst, ~exp_pc);
                checkOutput({name, " out_exc"}, 32'(bus.out_exc), 32'h0);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        if (got < n) checkOutput({name, " drain timeout"}, 32'(got), 32'(n));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rows[0] = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
        rows[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
        rows[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
        rows[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
        rows[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
        rows[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
        rows[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};

        // Reset values, then streaming with an always-ready memory.
        rst = 1'b1;
        mem_hold = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.mem_req_ready  = 1'b1;
        bus.out_ready      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset mem_req_valid", 32'(bus.mem_req_valid), 32'h0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("reset out_inst", bus.out_inst, 32'h0);
        checkOutput("reset out_pc", bus.out_pc, 32'h0);
        checkOutput("reset out_exc", 32'(bus.out_exc), 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("release mem_req_valid", 32'(bus.mem_req_valid), 32'h0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            applyStimulus(rows[i]);
            #1;
            checkOutput($sformatf("row%0d req_valid", i), 32'(bus.mem_req_valid), 32'(rows[i].exp_req_valid));
            if (rows[i].exp_req_valid)
                checkOutput($sformatf("row%0d req_addr", i), bus.mem_req_addr, rows[i].exp_req_addr);
            checkOutput($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(rows[i].exp_out_valid));
            if (rows[i].exp_out_valid) begin
                checkOutput($sformatf("row%0d out_pc", i), bus.out_pc, rows[i].exp_out_pc);
                checkOutput($sformatf("row%0d out_inst", i), bus.out_inst, ~rows[i].exp_out_pc);
            end
        end

        // Decode stalled: only two words may be outstanding, none lost.
        doReset();
        bus.out_ready = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("stall accepts", 32'(acc_cnt), 32'd2);
        checkOutput("stall req_valid", 32'(bus.mem_req_valid), 32'h0);
        checkOutput("stall out_pc", bus.out_pc, 32'h0);
        drainExpect("stall", 32'h0, 4);

        // Redirect with two requests in flight: both responses must be discarded.
        doReset();
        mem_hold = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("inflight accepts", 32'(acc_cnt), 32'd2);
        checkOutput("inflight req_valid", 32'(bus.mem_req_valid), 32'h0);
        mem_hold = 1'b0;
        doRedirect(32'h0000_0100);
        checkOutput("redir out_valid", 32'(bus.out_valid), 32'h0);
        drainExpect("redir100", 32'h0000_0100, 3);

        // Redirect while a request is held by memory: old address stays, then is dropped.
        doReset();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        checkOutput("held addr0", bus.mem_req_addr, 32'h0);
        @(negedge clk);
        doRedirect(32'h0000_0200);
        checkOutput("held valid", 32'(bus.mem_req_valid), 32'h1);
        checkOutput("held addr1", bus.mem_req_addr, 32'h0);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        checkOutput("post-stale addr", bus.mem_req_addr, 32'h0000_0200);
        drainExpect("redir200", 32'h0000_0200, 2);

        // PC wraps from the top word back to zero.
        doReset();
        repeat (3) @(negedge clk);
        doRedirect(32'hFFFF_FFFC);
        checkOutput("wrap out_valid", 32'(bus.out_valid), 32'h0);
        drainExpect("wrap", 32'hFFFF_FFFC, 3);

        // Back-to-back redirects: the last one wins.
        doReset();
        repeat (2) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0300;
        @(negedge clk);
        bus.redirect_pc    = 32'h0000_0400;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        drainExpect("b2b", 32'h0000_0400, 2);

`ifdef IFETCH_MISALIGN_EXC_EN
        begin
            int wait_cyc;
            doReset();
            @(negedge clk);
            bus.out_ready = 1'b0;
            doRedirect(32'h0000_0102);
            checkOutput("exc t+1 out_valid", 32'(bus.out_valid), 32'h0);
            wait_cyc = 0;
            while (!bus.out_valid && wait_cyc < 10) begin
                @(negedge clk);
                wait_cyc++;
            end
            checkOutput("exc out_valid", 32'(bus.out_valid), 32'h1);
            checkOutput("exc out_exc", 32'(bus.out_exc), 32'h1);
            checkOutput("exc out_pc", bus.out_pc, 32'h0000_0102);
            checkOutput("exc out_inst", bus.out_inst, 32'h0);
            repeat (5) @(negedge clk);
            checkOutput("exc halted req", 32'(bus.mem_req_valid), 32'h0);
            checkOutput("exc held", 32'(bus.out_valid), 32'h1);
            bus.out_ready = 1'b1;
            @(negedge clk);
            checkOutput("exc popped", 32'(bus.out_valid), 32'h0);
            checkOutput("exc still halted", 32'(bus.mem_req_valid), 32'h0);
            doRedirect(32'h0000_0040);
            drainExpect("resume", 32'h0000_0040, 2);
        end
`else
        doReset();
        @(negedge clk);
        doRedirect(32'h0000_0102);
        drainExpect("trunc", 32'h0000_0100, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
